// File: rtl/pixel_pack_fifo.sv
// Packs byte pairs into RGB565 words and buffers them in a first-word-fall-through FIFO.
// A frame-start pulse flushes both the FIFO and the byte packer.
module pixel_pack_fifo #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FrameCtrl,
    input  logic          ByteWe,
    input  logic [7:0]    ByteData,
    input  logic          FIFO_Re,
    output logic [15:0]   FIFO_Data,
    output logic          FIFO_Empty,
    output logic          FIFO_Full,
    output logic [AW:0]   FIFO_Level,
    output logic          Overflow,
    output logic          Underflow
);
    typedef enum logic {StHi, StLo} pack_state_e;

    localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);

    logic [15:0] mem [DEPTH];

    pack_state_e state_q, state_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        empty_q, empty_d, full_q, full_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        push_req, do_push, do_pop;
    logic [15:0] word;

    always_comb begin
        state_d   = state_q;
        hi_byte_d = hi_byte_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        word      = {hi_byte_q, ByteData};
        push_req  = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;

        if (FrameCtrl) begin
            // A byte arriving with the flush starts the new frame's first pair.
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            state_d   = ByteWe ? StLo : StHi;
            hi_byte_d = ByteWe ? ByteData : hi_byte_q;
        end else begin
            if (ByteWe) begin
                if (state_q == StHi) begin
                    hi_byte_d = ByteData;
                    state_d   = StLo;
                end else begin
                    push_req = 1'b1;
                    state_d  = StHi;
                end
            end

            do_pop  = FIFO_Re && !empty_q;
            do_push = push_req && (!full_q || do_pop);

            if (FIFO_Re && empty_q) unf_d = 1'b1;
            if (push_req && !do_push) ovf_d = 1'b1;

            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == LevelFull);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StHi;
            hi_byte_q <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_byte_q <= hi_byte_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && do_push) mem[wr_ptr_q] <= word;
    end

    assign FIFO_Data  = empty_q ? 16'h0000 : mem[rd_ptr_q];
    assign FIFO_Empty = empty_q;
    assign FIFO_Full  = full_q;
    assign FIFO_Level = level_q;
    assign Overflow   = ovf_q;
    assign Underflow  = unf_q;
endmodule

// File: tb/tb_pixel_pack_fifo.sv
// Scoreboard bench for pixel_pack_fifo: a behavioural packer/FIFO model queues expected words.
module tb_pixel_pack_fifo;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_ctrl;
    logic          byte_we;
    logic [7:0]    byte_data;
    logic          fifo_re;
    logic [15:0]   fifo_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic        m_lo;
    logic [7:0]  m_hi;
    logic        m_ovf;
    logic        m_unf;

    always #5 clk = ~clk;

    pixel_pack_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .FrameCtrl (frame_ctrl),
        .ByteWe    (byte_we),
        .ByteData  (byte_data),
        .FIFO_Re   (fifo_re),
        .FIFO_Data (fifo_data),
        .FIFO_Empty(fifo_empty),
        .FIFO_Full (fifo_full),
        .FIFO_Level(fifo_level),
        .Overflow  (overflow),
        .Underflow (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        int sz = exp_q.size();
        check("level", 32'(fifo_level), 32'(sz));
        check("empty", 32'(fifo_empty), 32'(sz == 0));
        check("full", 32'(fifo_full), 32'(sz == DEPTH));
        check("ovf", 32'(overflow), 32'(m_ovf));
        check("unf", 32'(underflow), 32'(m_unf));
        if (sz == 0) check("data_empty", 32'(fifo_data), 32'h0);
        else         check("data_head", 32'(fifo_data), 32'(exp_q[0]));
    endtask

    // One clock cycle of stimulus; model updated from the pre-edge state, DUT checked after the edge.
    task automatic step(input logic we, input logic [7:0] d, input logic re, input logic fr);
        int   sz;
        logic pop;
        byte_we    = we;
        byte_data  = d;
        fifo_re    = re;
        frame_ctrl = fr;
        if (fr) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            if (we) begin
                m_lo = 1'b1;
                m_hi = d;
            end else begin
                m_lo = 1'b0;
            end
        end else begin
            sz  = exp_q.size();
            pop = re && (sz > 0);
            if (re && sz == 0) m_unf = 1'b1;
            if (pop) begin
                check("pop_data", 32'(fifo_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            if (we) begin
                if (!m_lo) begin
                    m_hi = d;
                    m_lo = 1'b1;
                end else begin
                    m_lo = 1'b0;
                    if (sz < DEPTH || pop) exp_q.push_back({m_hi, d});
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic push_word(input logic [15:0] w);
        step(1'b1, w[15:8], 1'b0, 1'b0);
        step(1'b1, w[7:0], 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; frame_ctrl = 1'b0; byte_we = 1'b0; byte_data = 8'h00; fifo_re = 1'b0;
        m_lo = 1'b0; m_hi = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
        check("rst_data", 32'(fifo_data), 32'h0);

        // Basic pack and pop
        step(1'b1, 8'h12, 1'b0, 1'b0);
        check("half_empty", 32'(fifo_empty), 32'h1);
        step(1'b1, 8'h34, 1'b0, 1'b0);
        check("pack_data", 32'(fifo_data), 32'h1234);
        check("pack_level", 32'(fifo_level), 32'h1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_empty", 32'(fifo_empty), 32'h1);

        // Fill to full, then one extra word is dropped
        for (int i = 0; i < DEPTH; i++) push_word(16'(i * 37 + 16'h0a05));
        check("fill_full", 32'(fifo_full), 32'h1);
        push_word(16'hdead);
        check("fill_level", 32'(fifo_level), 32'(DEPTH));
        check("fill_ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_empty", 32'(fifo_empty), 32'h1);

        // Concurrent push/pop at level 1 and at full
        step(1'b0, 8'h00, 1'b0, 1'b1);
        push_word(16'hbeef);
        step(1'b1, 8'hc0, 1'b0, 1'b0);
        step(1'b1, 8'hde, 1'b1, 1'b0);
        check("conc_level1", 32'(fifo_level), 32'h1);
        check("conc_data1", 32'(fifo_data), 32'hc0de);
        for (int i = 1; i < DEPTH; i++) push_word(16'(i ^ 16'h5a00));
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h88, 1'b1, 1'b0);
        check("conc_full", 32'(fifo_full), 32'h1);
        check("conc_ovf", 32'(overflow), 32'h0);

        // Underflow, flush clears it; flush with a read does not set it
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_set", 32'(underflow), 32'h1);
        check("unf_data", 32'(fifo_data), 32'h0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr", 32'(underflow), 32'h0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("flush_re", 32'(underflow), 32'h0);

        // Simultaneous push and pop while empty: push only
        step(1'b1, 8'h21, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b1, 1'b0);
        check("emp_conc_unf", 32'(underflow), 32'h1);
        check("emp_conc_data", 32'(fifo_data), 32'h2143);

        // Mid-pair flush
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'haa, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        check("midflush_data", 32'(fifo_data), 32'h5566);
        check("midflush_level", 32'(fifo_level), 32'h1);

        // Random traffic with occasional flushes
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 150) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
